// File: rtl/decode_stage.sv
// LC-3b decode stage: one-entry IR1/PC buffer, 8x16 register file, load-use interlock.
// Define WB_BYPASS_EN to forward same-cycle register writes to the operand reads.
module decode_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_valid,
  input  logic [15:0] if_instr,
  input  logic [15:0] if_pc,
  output logic        if_stall,
  output logic        id_valid,
  input  logic        ex_ready,
  output logic [15:0] id_src1,
  output logic [15:0] id_src2,
  output logic [15:0] id_adj6,
  output logic [15:0] id_pc,
  output logic [3:0]  id_opcode,
  output logic [2:0]  id_dr,
  input  logic        ex_is_load,
  input  logic [2:0]  ex_dr,
  input  logic        wb_we,
  input  logic [2:0]  wb_dr,
  input  logic [15:0] wb_data
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    STALL = 2'd2
  } state_e;

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_LDB = 4'b0010;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_STB = 4'b0011;
  localparam logic [3:0] OP_JMP = 4'b1100;

  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] rf_q [8];

  logic [3:0] op;
  logic [2:0] sr1, sr2;
  logic       is_alu, is_st, use1, use2;
  logic       ld_haz, wb_haz, hazard;
  logic       occupied, xfer;

  assign op     = ir_q[15:12];
  assign is_alu = (op == OP_ADD) | (op == OP_AND);
  assign is_st  = (op == OP_STR) | (op == OP_STB);
  assign use1   = is_alu | is_st | (op == OP_NOT)
                | (op == OP_LDR) | (op == OP_LDB)
                | (op == OP_JMP);
  assign use2   = (is_alu & ~ir_q[5]) | is_st;
  assign sr1    = ir_q[8:6];
  assign sr2    = is_st ? ir_q[11:9] : ir_q[2:0];

  assign ld_haz = ex_is_load
                & ((use1 & (ex_dr == sr1))
                |  (use2 & (ex_dr == sr2)));

`ifdef WB_BYPASS_EN
  assign wb_haz  = 1'b0;
  assign id_src1 = (wb_we && wb_dr == sr1) ? wb_data : rf_q[sr1];
  assign id_src2 = (wb_we && wb_dr == sr2) ? wb_data : rf_q[sr2];
`else
  // A read racing a write waits one cycle for the written value.
  assign wb_haz  = wb_we
                 & ((use1 & (wb_dr == sr1))
                 |  (use2 & (wb_dr == sr2)));
  assign id_src1 = rf_q[sr1];
  assign id_src2 = rf_q[sr2];
`endif

  assign hazard    = ld_haz | wb_haz;
  assign occupied  = (state_q != EMPTY);
  assign id_valid  = occupied & ~hazard;
  assign xfer      = id_valid & ex_ready;
  assign if_stall  = occupied & ~xfer;

  assign id_adj6   = {{9{ir_q[5]}}, ir_q[5:0], 1'b0};
  assign id_dr     = ir_q[11:9];
  assign id_opcode = op;
  assign id_pc     = pc_q;

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    pc_d    = pc_q;
    case (state_q)
      EMPTY: begin
        if (if_valid) begin
          state_d = FULL;
          ir_d    = if_instr;
          pc_d    = if_pc;
        end
      end
      FULL, STALL: begin
        if (hazard) begin
          state_d = STALL;
        end else if (xfer) begin
          if (if_valid) begin
            state_d = FULL;
            ir_d    = if_instr;
            pc_d    = if_pc;
          end else begin
            state_d = EMPTY;
          end
        end else begin
          state_d = FULL;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      ir_q    <= '0;
      pc_q    <= '0;
      for (int i = 0; i < 8; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      pc_q    <= pc_d;
      if (wb_we) rf_q[wb_dr] <= wb_data;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed instructions, expected operands
// queued at issue and compared by a monitor on every transfer.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_valid;
  logic [15:0] if_instr, if_pc;
  logic        if_stall, id_valid, ex_ready;
  logic [15:0] id_src1, id_src2, id_adj6, id_pc;
  logic [3:0]  id_opcode;
  logic [2:0]  id_dr;
  logic        ex_is_load;
  logic [2:0]  ex_dr;
  logic        wb_we;
  logic [2:0]  wb_dr;
  logic [15:0] wb_data;

  decode_stage dut (
    .clk(clk), .reset(reset),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .if_stall(if_stall), .id_valid(id_valid), .ex_ready(ex_ready),
    .id_src1(id_src1), .id_src2(id_src2), .id_adj6(id_adj6),
    .id_pc(id_pc), .id_opcode(id_opcode), .id_dr(id_dr),
    .ex_is_load(ex_is_load), .ex_dr(ex_dr),
    .wb_we(wb_we), .wb_dr(wb_dr), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] s1, s2, adj, pc;
    logic [3:0]  op;
    logic [2:0]  dr;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  always @(negedge clk) begin
    if (id_valid === 1'b1 && ex_ready === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_extra got pc=%h op=%h required=none", id_pc, id_opcode);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (id_src1 !== e.s1 || id_src2 !== e.s2 || id_adj6 !== e.adj ||
            id_pc !== e.pc || id_opcode !== e.op || id_dr !== e.dr) begin
          failures++;
          $display("FAIL xfer got s1=%h s2=%h adj=%h pc=%h op=%h dr=%0d required s1=%h s2=%h adj=%h pc=%h op=%h dr=%0d",
                   id_src1, id_src2, id_adj6, id_pc, id_opcode, id_dr,
                   e.s1, e.s2, e.adj, e.pc, e.op, e.dr);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic push(input logic [15:0] s1, input logic [15:0] s2,
                      input logic [15:0] adj, input logic [15:0] pc,
                      input logic [3:0] op, input logic [2:0] dr);
    exp_t e;
    e.s1 = s1; e.s2 = s2; e.adj = adj; e.pc = pc; e.op = op; e.dr = dr;
    sb.push_back(e);
  endtask

  task automatic present(input logic [15:0] instr, input logic [15:0] pc);
    if_valid = 1'b1;
    if_instr = instr;
    if_pc    = pc;
  endtask

  task automatic wait_accept();
    bit done = 0;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      if (if_stall === 1'b0) done = 1;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=stalled required=accepted");
    end
    @(posedge clk);
    #1;
    if_valid = 1'b0;
  endtask

  task automatic write(input logic [2:0] r, input logic [15:0] d);
    wb_we = 1'b1; wb_dr = r; wb_data = d;
    tick();
    wb_we = 1'b0;
  endtask

  initial begin
    reset = 1'b1; if_valid = 1'b0; if_instr = '0; if_pc = '0;
    ex_ready = 1'b1; ex_is_load = 1'b0; ex_dr = '0;
    wb_we = 1'b0; wb_dr = '0; wb_data = '0;
    tick();
    @(negedge clk);
    chk("rst_id_valid", {15'd0, id_valid}, 16'd0);
    chk("rst_if_stall", {15'd0, if_stall}, 16'd0);
    tick();
    reset = 1'b0;

    write(3'd1, 16'h1234);
    write(3'd2, 16'h0F0F);

    // ADD R3,R1,R2
    push(16'h1234, 16'h0F0F, 16'h0004, 16'h3002, 4'h1, 3'd3);
    present(16'h1642, 16'h3002);
    wait_accept();
    @(negedge clk);
    chk("add_valid", {15'd0, id_valid}, 16'd1);
    tick();

    // LDR R4,R1,#-1 under load-use hazard on R1
    ex_is_load = 1'b1; ex_dr = 3'd1;
    push(16'h1234, 16'h0000, 16'hFFFE, 16'h3004, 4'h6, 3'd4);
    present(16'h687F, 16'h3004);
    wait_accept();
    repeat (3) begin
      @(negedge clk);
      chk("ld_valid", {15'd0, id_valid}, 16'd0);
      chk("ld_stall", {15'd0, if_stall}, 16'd1);
    end
    tick();
    ex_is_load = 1'b0;
    @(negedge clk);
    chk("ld_adj6", id_adj6, 16'hFFFE);
    chk("ld_valid_after", {15'd0, id_valid}, 16'd1);
    tick();

    // AND R5,R1,#3 held by ex_ready=0 while STR waits in fetch
    ex_ready = 1'b0;
    push(16'h1234, 16'h0000, 16'hFFC6, 16'h3006, 4'h5, 3'd5);
    present(16'h5A63, 16'h3006);
    wait_accept();
    push(16'h1234, 16'h0F0F, 16'h0002, 16'h3008, 4'h7, 3'd2);
    present(16'h7441, 16'h3008);
    repeat (3) begin
      @(negedge clk);
      chk("hold_src1", id_src1, 16'h1234);
      chk("hold_adj6", id_adj6, 16'hFFC6);
      chk("hold_pc", id_pc, 16'h3006);
      chk("hold_stall", {15'd0, if_stall}, 16'd1);
    end
    @(posedge clk);
    #1;
    ex_ready = 1'b1;
    wait_accept();
    idle(2);

    // ADD R6,R1,R2 while R1 is written with BEEF
    ex_ready = 1'b0;
    push(16'hBEEF, 16'h0F0F, 16'h0004, 16'h300A, 4'h1, 3'd6);
    present(16'h1C42, 16'h300A);
    wait_accept();
    wb_we = 1'b1; wb_dr = 3'd1; wb_data = 16'hBEEF;
    ex_ready = 1'b1;
    @(negedge clk);
`ifdef WB_BYPASS_EN
    chk("byp_valid", {15'd0, id_valid}, 16'd1);
    chk("byp_src1", id_src1, 16'hBEEF);
    tick();
    wb_we = 1'b0;
`else
    chk("byp_bubble_valid", {15'd0, id_valid}, 16'd0);
    chk("byp_bubble_stall", {15'd0, if_stall}, 16'd1);
    tick();
    wb_we = 1'b0;
    @(negedge clk);
    chk("byp_valid_next", {15'd0, id_valid}, 16'd1);
    chk("byp_src1_next", id_src1, 16'hBEEF);
    tick();
`endif
    idle(2);

    // NOT R7,R1 stalled, then reset with a pending write
    ex_is_load = 1'b1; ex_dr = 3'd1;
    present(16'h9E7F, 16'h300C);
    wait_accept();
    @(negedge clk);
    chk("pre_rst_stall", {15'd0, if_stall}, 16'd1);
    chk("pre_rst_valid", {15'd0, id_valid}, 16'd0);
    tick();
    reset = 1'b1;
    wb_we = 1'b1; wb_dr = 3'd2; wb_data = 16'hAAAA;
    tick();
    reset = 1'b0; wb_we = 1'b0; ex_is_load = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", {15'd0, id_valid}, 16'd0);
    chk("post_rst_stall", {15'd0, if_stall}, 16'd0);
    tick();

    // ADD R0,Ri,Ri for every register: all must read zero
    for (int i = 0; i < 8; i++) begin
      logic [2:0]  r;
      logic [15:0] ins, pc;
      r   = 3'(i);
      ins = {4'b0001, 3'd0, r, 3'b000, r};
      pc  = 16'h4000 + 16'(2 * i);
      push(16'h0000, 16'h0000, 16'(2 * i), pc, 4'h1, 3'd0);
      present(ins, pc);
      wait_accept();
    end
    idle(3);
    chk("sb_drained", 16'(sb.size()), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, sampled on the rising edge of clk.
REQ-002 clk  in  1  clock; all state updates on the rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 if_valid  in  1  fetch presents a valid instruction.
REQ-005 if_instr  in  16  instruction word (lc3b_word).
REQ-006 if_pc  in  16  PC+2 of that instruction.
REQ-007 if_stall  out  1  fetch SHALL hold if_instr/if_pc while high.
REQ-008 id_valid  out  1  operands on id_* are valid for the downstream operand register.
REQ-009 ex_ready  in  1  the downstream operand register loads this cycle; transfer = id_valid & ex_ready.
REQ-010 id_src1, id_src2, id_adj6, id_pc  out  16 each  operand 1, operand 2, offset, PC.
REQ-011 id_opcode  out  4 and id_dr  out  3  opcode and destination register.
REQ-012 ex_is_load  in  1 and ex_dr  in  3  execute stage holds LDR/LDB writing ex_dr.
REQ-013 wb_we  in  1, wb_dr  in  3 and wb_data  in  16  register-file write port.

Function
REQ-014 The block SHALL contain an 8x16 register file, written at the clock edge when wb_we=1.
REQ-015 The block SHALL contain a one-entry instruction register (IR1 plus PC), with state machine EMPTY / FULL / STALL.
REQ-016 EMPTY: if_valid=1 SHALL load IR1 and go to FULL; otherwise remain EMPTY; if_stall=0.
REQ-017 FULL with no hazard: id_valid=1. On transfer, IR1 SHALL reload from fetch if if_valid=1 (stay FULL), else go to EMPTY. Without transfer, hold IR1 with if_stall=1.
REQ-018 A load-use hazard exists when ex_is_load=1 and ex_dr equals a register read by IR1 (REQ-021).
REQ-019 On a hazard, FULL SHALL go to STALL: id_valid=0, if_stall=1, IR1 held.
REQ-020 STALL SHALL return to FULL on the first cycle the hazard is absent.
REQ-021 Read sources are as follows.
  - SR1 = IR1[8:6]: used by ADD, AND, NOT, LDR, LDB, STR, STB, JMP.
  - SR2 = IR1[2:0]: used by ADD/AND when IR1[5]=0.
  - SR2 = IR1[11:9]: used by STR/STB.
REQ-022 id_src1 and id_src2 SHALL be register-file reads of the selected addresses.
REQ-023 id_adj6 SHALL be sign-extended IR1[5:0] shifted left by 1.
REQ-024 id_dr SHALL be IR1[11:9], id_opcode SHALL be IR1[15:12], and id_pc SHALL be the stored PC.
REQ-025 if_stall SHALL equal (state!=EMPTY) & ~(id_valid & ex_ready).
REQ-026 id_* SHALL remain stable while id_valid=1 and ex_ready=0.
REQ-027 A wb_we write to a register IR1 reads, in the same cycle as a stall, SHALL be visible on the next cycle's outputs.

Reset
REQ-028 On reset the state SHALL be EMPTY, with id_valid=0 and if_stall=0.
REQ-029 On reset IR1 and the PC register SHALL be 0, and all eight registers SHALL be 0x0000.
REQ-030 Reset SHALL override any in-flight instruction, hazard or write in that cycle.

Configuration
REQ-031 Macro WB_BYPASS_EN defined: a read whose address equals wb_dr while wb_we=1 SHALL return wb_data in the same cycle.
REQ-032 WB_BYPASS_EN undefined: that condition SHALL be treated as a hazard (id_valid=0, if_stall=1 for that cycle); the read returns the written value next cycle.

Verification
REQ-033 Reset then write R1=0x1234 and R2=0x0F0F; present ADD R3,R1,R2 (0x1642) with ex_ready=1. Required: id_valid=1 one cycle after load, id_src1=0x1234, id_src2=0x0F0F, id_dr=3.
REQ-034 ex_is_load=1, ex_dr=1, with LDR R4,R1,#-1 (0x687F) in IR1. Required: id_valid=0 and if_stall=1 until ex_is_load drops, then id_adj6=0xFFFE and id_valid=1.
REQ-035 ex_ready=0 for 3 cycles with IR1 FULL. Required: id_* constant, if_stall=1, no instruction lost or duplicated after ex_ready returns.
REQ-036 wb_we=1, wb_dr=1, wb_data=0xBEEF in the cycle ADD reads R1. With WB_BYPASS_EN: id_src1=0xBEEF that cycle. Without: one bubble, then 0xBEEF.
REQ-037 Assert reset while in STALL with pending wb_we. Required: next cycle EMPTY, id_valid=0, all registers read 0x0000.
